// File: rtl/alu_issue_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_issue_sequencer_if
// Bundles the instruction handshake, the ALU control/operand bus, the
// writeback report and the register-file preload port of the sequencer.
//   master : the sequencer side (drives instr_ready, ALU controls, writeback)
//   slave  : the environment side (fetch, external ALU, preload source)
// ---------------------------------------------------------------------------
interface alu_issue_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic [3:0]        alu_ctl;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_zero;
    logic              illegal;
    logic              init_we;
    logic [4:0]        init_addr;
    logic [DATA_W-1:0] init_data;

    modport master (
        input  instr_valid, instr, alu_out, alu_zero, init_we, init_addr, init_data,
        output instr_ready, alu_ctl, alu_a, alu_b,
               wb_valid, wb_rd, wb_data, wb_zero, illegal
    );

    modport slave (
        output instr_valid, instr, alu_out, alu_zero, init_we, init_addr, init_data,
        input  instr_ready, alu_ctl, alu_a, alu_b,
               wb_valid, wb_rd, wb_data, wb_zero, illegal
    );
endinterface

// File: rtl/alu_issue_sequencer.sv
// ---------------------------------------------------------------------------
// alu_issue_sequencer
// Accepts MIPS R-type instruction words, reads operands from an internal
// 32x32 register file, drives an external combinational ALU, captures the
// result and writes it back. One instruction in flight, 4 cycles each:
//   IDLE -> DECODE -> EXEC -> WB -> IDLE
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : alu_issue_sequencer_if.master
//                instr_valid/instr/instr_ready  instruction handshake
//                alu_ctl/alu_a/alu_b            to external ALU
//                alu_out/alu_zero               from external ALU
//                wb_valid/wb_rd/wb_data/wb_zero writeback report
//                illegal                        rejected-instruction pulse
//                init_we/init_addr/init_data    register-file preload
// ---------------------------------------------------------------------------
module alu_issue_sequencer #(
    parameter int          DATA_W   = 32,
    parameter logic [3:0]  IDLE_CTL = 4'hF
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_issue_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    // {legal, ctl} for an instruction word
    function automatic logic [4:0] decode_ctl(input logic [31:0] ins);
        logic [4:0] r;
        r = {1'b0, IDLE_CTL};
        if (ins[31:26] == 6'd0) begin
            case (ins[5:0])
                6'd32:   r = {1'b1, 4'd2};   // add
                6'd34:   r = {1'b1, 4'd6};   // sub
                6'd36:   r = {1'b1, 4'd0};   // and
                6'd37:   r = {1'b1, 4'd1};   // or
                6'd39:   r = {1'b1, 4'd12};  // nor
                6'd42:   r = {1'b1, 4'd7};   // slt
                default: r = {1'b0, IDLE_CTL};
            endcase
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [3:0]        ctl_q, ctl_d;
    logic              legal_q, legal_d;
    logic              instr_ready_q, instr_ready_d;
    logic [3:0]        alu_ctl_q, alu_ctl_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_zero_q, wb_zero_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];
    logic [4:0]        dec;

    // shamt takes no part in any operation
    logic unused_shamt;
    assign unused_shamt = ^bus.instr[10:6];

    assign dec = decode_ctl(bus.instr);

    always_comb begin
        state_d       = state_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        rd_d          = rd_q;
        ctl_d         = ctl_q;
        legal_d       = legal_q;
        instr_ready_d = instr_ready_q;
        alu_ctl_d     = alu_ctl_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        wb_zero_d     = wb_zero_q;
        illegal_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.instr_valid && instr_ready_q) begin
                    rs_d          = bus.instr[25:21];
                    rt_d          = bus.instr[20:16];
                    rd_d          = bus.instr[15:11];
                    // Decoding at the handshake lets the registered illegal
                    // pulse line up with the DECODE cycle itself.
                    legal_d       = dec[4];
                    ctl_d         = dec[3:0];
                    illegal_d     = ~dec[4];
                    instr_ready_d = 1'b0;
                    state_d       = DECODE;
                end
            end
            DECODE: begin
                if (legal_q) begin
                    alu_a_d   = regs_q[rs_q];
                    alu_b_d   = regs_q[rt_q];
                    alu_ctl_d = ctl_q;
                    state_d   = EXEC;
                end else begin
                    instr_ready_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            EXEC: begin
                wb_data_d  = bus.alu_out;
                wb_zero_d  = bus.alu_zero;
                wb_rd_d    = rd_q;
                wb_valid_d = 1'b1;
                state_d    = WB;
            end
            WB: begin
                alu_ctl_d     = IDLE_CTL;
                alu_a_d       = '0;
                alu_b_d       = '0;
                instr_ready_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register file next state: writeback is applied after the preload so it
    // wins a same-register collision; register 0 is never written.
    always_comb begin
        regs_d = regs_q;
        if (bus.init_we && bus.init_addr != 5'd0)
            regs_d[bus.init_addr] = bus.init_data;
        if (state_q == WB && wb_rd_q != 5'd0)
            regs_d[wb_rd_q] = wb_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            ctl_q         <= IDLE_CTL;
            legal_q       <= 1'b0;
            instr_ready_q <= 1'b1;
            alu_ctl_q     <= IDLE_CTL;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            wb_zero_q     <= 1'b0;
            illegal_q     <= 1'b0;
            regs_q        <= '{default: '0};
        end else begin
            state_q       <= state_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            ctl_q         <= ctl_d;
            legal_q       <= legal_d;
            instr_ready_q <= instr_ready_d;
            alu_ctl_q     <= alu_ctl_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            wb_zero_q     <= wb_zero_d;
            illegal_q     <= illegal_d;
            regs_q        <= regs_d;
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.alu_ctl     = alu_ctl_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_zero     = wb_zero_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
module tb_alu_issue_sequencer;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_sequencer_if #(.DATA_W(DATA_W)) bus ();

    alu_issue_sequencer #(.DATA_W(DATA_W), .IDLE_CTL(4'hF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // External combinational ALU
    always_comb begin
        case (bus.alu_ctl)
            4'd2:    bus.alu_out = bus.alu_a + bus.alu_b;
            4'd6:    bus.alu_out = bus.alu_a - bus.alu_b;
            4'd0:    bus.alu_out = bus.alu_a & bus.alu_b;
            4'd1:    bus.alu_out = bus.alu_a | bus.alu_b;
            4'd12:   bus.alu_out = ~(bus.alu_a | bus.alu_b);
            4'd7:    bus.alu_out = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            default: bus.alu_out = '0;
        endcase
    end
    assign bus.alu_zero = (bus.alu_out == '0);

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_rf [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---- reference model: instruction semantics straight from funct ----
    function automatic bit ref_legal(input logic [31:0] ins);
        logic [5:0] f;
        f = ins[5:0];
        return ins[31:26] == 6'd0 &&
               (f == 6'd32 || f == 6'd34 || f == 6'd36 || f == 6'd37 || f == 6'd39 || f == 6'd42);
    endfunction

    function automatic logic [3:0] ref_ctl(input logic [5:0] f);
        case (f)
            6'd32: return 4'd2;
            6'd34: return 4'd6;
            6'd36: return 4'd0;
            6'd37: return 4'd1;
            6'd39: return 4'd12;
            6'd42: return 4'd7;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            6'd32: return a + b;
            6'd34: return a - b;
            6'd36: return a & b;
            6'd37: return a | b;
            6'd39: return ~(a | b);
            6'd42: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] f);
        return {6'd0, rs, rt, rd, 5'd0, f};
    endfunction

    task automatic init_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.init_we = 1'b1; bus.init_addr = a; bus.init_data = d;
        @(negedge clk);
        bus.init_we = 1'b0;
        if (a != 5'd0) ref_rf[a] = d;
    endtask

    // Issue one instruction and check every cycle of its life.
    // coll: 0 none, 1 preload rs during DECODE, 2 preload rd during WB.
    task automatic run(input logic [31:0] ins, input int coll, input logic [31:0] cdata,
                       output logic o_ill, output logic [3:0] o_ctl,
                       output logic [31:0] o_data, output logic o_zero);
        logic [4:0]  rs, rt, rd;
        logic [5:0]  f;
        logic        legal;
        logic [31:0] a, b, exp;
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; f = ins[5:0];
        legal = ref_legal(ins);
        a = ref_rf[rs]; b = ref_rf[rt];
        exp = ref_op(f, a, b);
        o_data = 'x; o_zero = 1'bx;

        @(negedge clk);
        chk("ready_before_issue", bus.instr_ready, 1);
        bus.instr_valid = 1'b1; bus.instr = ins;
        @(negedge clk);                        // DECODE cycle
        bus.instr_valid = 1'b0;
        o_ill = bus.illegal;
        chk("ready_in_decode", bus.instr_ready, 0);
        chk("illegal_pulse", bus.illegal, !legal);
        chk("ctl_idle_in_decode", bus.alu_ctl, 4'hF);
        chk("no_wb_in_decode", bus.wb_valid, 0);
        if (coll == 1) begin
            bus.init_we = 1'b1; bus.init_addr = rs; bus.init_data = cdata;
        end
        @(negedge clk);                        // EXEC (or IDLE when illegal)
        bus.init_we = 1'b0;
        if (coll == 1 && rs != 5'd0) ref_rf[rs] = cdata;
        o_ctl = bus.alu_ctl;
        if (!legal) begin
            chk("illegal_one_cycle", bus.illegal, 0);
            chk("ready_after_illegal", bus.instr_ready, 1);
            chk("no_wb_after_illegal", bus.wb_valid, 0);
        end else begin
            chk("exec_ctl", bus.alu_ctl, ref_ctl(f));
            chk("exec_a", bus.alu_a, a);
            chk("exec_b", bus.alu_b, b);
            chk("no_wb_in_exec", bus.wb_valid, 0);
            @(negedge clk);                    // WB
            o_data = bus.wb_data; o_zero = bus.wb_zero;
            chk("wb_valid", bus.wb_valid, 1);
            chk("wb_rd", bus.wb_rd, rd);
            chk("wb_data", bus.wb_data, exp);
            chk("wb_zero", bus.wb_zero, exp == 0);
            chk("ctl_held_in_wb", bus.alu_ctl, ref_ctl(f));
            if (coll == 2) begin
                bus.init_we = 1'b1; bus.init_addr = rd; bus.init_data = cdata;
            end
            @(negedge clk);                    // back to IDLE
            bus.init_we = 1'b0;
            if (rd != 5'd0) ref_rf[rd] = exp;
            chk("wb_pulse_ends", bus.wb_valid, 0);
            chk("ready_after_wb", bus.instr_ready, 1);
            chk("ctl_idle_after_wb", bus.alu_ctl, 4'hF);
            chk("a_zero_after_wb", bus.alu_a, 0);
            chk("b_zero_after_wb", bus.alu_b, 0);
            chk("wb_data_holds", bus.wb_data, exp);
        end
    endtask

    // Read a register through "or $0, rk, $0"; run() checks wb_data against the model.
    task automatic read_reg(input logic [4:0] k);
        logic i; logic [3:0] c; logic [31:0] d; logic z;
        run(mk_r(k, 5'd0, 5'd0, 6'd37), 0, 0, i, c, d, z);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        ill;
        logic [3:0]  ctl;
        logic [31:0] data;
        logic        zero;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        oi, oz;
        logic [3:0]  oc;
        logic [31:0] od;
        logic [5:0]  legal_f [6];

        legal_f = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
        // r1 = F0F0_0000, r2 = 0FF0_0001
        tbl[0] = '{mk_r(1, 2, 7,  6'd36), 1'b0, 4'd0,  32'h00F0_0000, 1'b0};
        tbl[1] = '{mk_r(1, 2, 8,  6'd37), 1'b0, 4'd1,  32'hFFF0_0001, 1'b0};
        tbl[2] = '{mk_r(1, 2, 9,  6'd39), 1'b0, 4'd12, 32'h000F_FFFE, 1'b0};
        tbl[3] = '{mk_r(1, 2, 10, 6'd42), 1'b0, 4'd7,  32'h0000_0001, 1'b0};
        tbl[4] = '{mk_r(1, 2, 11, 6'd32), 1'b0, 4'd2,  32'h00E0_0001, 1'b0};
        tbl[5] = '{mk_r(1, 2, 12, 6'd34), 1'b0, 4'd6,  32'hE0FF_FFFF, 1'b0};
        tbl[6] = '{mk_r(2, 1, 13, 6'd42), 1'b0, 4'd7,  32'h0000_0000, 1'b1};
        tbl[7] = '{mk_r(1, 2, 14, 6'd0),  1'b1, 4'hF,  32'h0,         1'b0};
        tbl[8] = '{{6'h23, 5'd1, 5'd2, 5'd14, 5'd0, 6'd32}, 1'b1, 4'hF, 32'h0, 1'b0};
        tbl[9] = '{mk_r(1, 0, 14, 6'd36), 1'b0, 4'd0,  32'h0,         1'b1};

        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        reset = 1'b1;
        bus.instr_valid = 1'b0; bus.instr = '0;
        bus.init_we = 1'b0; bus.init_addr = '0; bus.init_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_ctl", bus.alu_ctl, 4'hF);
        chk("rst_a", bus.alu_a, 0);
        chk("rst_b", bus.alu_b, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_rd", bus.wb_rd, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_wb_zero", bus.wb_zero, 0);
        chk("rst_illegal", bus.illegal, 0);
        for (int k = 0; k < 32; k++) read_reg(k[4:0]);

        // add with latency
        init_wr(1, 32'd5); init_wr(2, 32'd7);
        run(32'h0022_1820, 0, 0, oi, oc, od, oz);
        chk("add_ctl", oc, 4'd2);
        chk("add_data", od, 32'd12);
        chk("add_zero", oz, 0);

        // sub to zero, then dependent or
        init_wr(1, 32'd9); init_wr(2, 32'd9);
        run(mk_r(1, 2, 4, 6'd34), 0, 0, oi, oc, od, oz);
        chk("sub_zero_data", od, 0);
        chk("sub_zero_flag", oz, 1);
        run(mk_r(4, 1, 5, 6'd37), 0, 0, oi, oc, od, oz);
        chk("dependent_or", od, 32'd9);

        // table sweep
        init_wr(1, 32'hF0F0_0000); init_wr(2, 32'h0FF0_0001);
        for (int i = 0; i < 10; i++) begin
            run(tbl[i].instr, 0, 0, oi, oc, od, oz);
            chk($sformatf("tbl%0d_illegal", i), oi, tbl[i].ill);
            chk($sformatf("tbl%0d_ctl", i), oc, tbl[i].ctl);
            if (!tbl[i].ill) begin
                chk($sformatf("tbl%0d_data", i), od, tbl[i].data);
                chk($sformatf("tbl%0d_zero", i), oz, tbl[i].zero);
            end
        end

        // $zero destination and preload to r0
        run(mk_r(1, 2, 0, 6'd32), 0, 0, oi, oc, od, oz);
        chk("r0_dest_data", od, 32'h00E0_0001);
        init_wr(0, 32'hDEAD_BEEF);
        read_reg(0);

        // collisions: preload during DECODE (old value used), preload vs WB (WB wins)
        run(mk_r(1, 2, 15, 6'd32), 1, 32'h1234_5678, oi, oc, od, oz);
        chk("decode_init_old", od, 32'h00E0_0001);
        read_reg(1);
        run(mk_r(1, 2, 16, 6'd37), 2, 32'hAAAA_5555, oi, oc, od, oz);
        read_reg(16);

        // randomized
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ins;
            if ($urandom_range(0, 2) == 0) init_wr(5'($urandom_range(0, 31)), $urandom);
            ins = mk_r(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), legal_f[$urandom_range(0, 5)]);
            if ($urandom_range(0, 7) == 0) ins[5:0] = 6'($urandom);
            if ($urandom_range(0, 9) == 0) ins[31:26] = 6'($urandom_range(1, 63));
            run(ins, int'($urandom_range(0, 2)), $urandom, oi, oc, od, oz);
        end
        for (int k = 0; k < 32; k++) read_reg(k[4:0]);

        // reset during EXEC
        init_wr(1, 32'd3); init_wr(2, 32'd4);
        @(negedge clk);
        bus.instr_valid = 1'b1; bus.instr = mk_r(1, 2, 6, 6'd32);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);                        // EXEC
        chk("pre_reset_exec_ctl", bus.alu_ctl, 4'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_no_wb", bus.wb_valid, 0);
        chk("midrst_ctl", bus.alu_ctl, 4'hF);
        chk("midrst_wb_data", bus.wb_data, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", bus.instr_ready, 1);
        chk("midrst_no_wb_after", bus.wb_valid, 0);
        chk("midrst_no_illegal", bus.illegal, 0);
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        for (int k = 0; k < 32; k++) read_reg(k[4:0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
